frodo_mul_seq: RTL and testbench
================================

Name: frodo_mul_seq

Overview:
- Control sequencer for the shared FrodoKEM multiply-accumulate datapath (A-wide operand `a`, S-row state, 8x4 by default).
- Accepts one command per operation: mode (mul1 vector-accumulate or mul2 matrix-accumulate), sign, and a beat count.
- Drives the datapath strobes `setStorage`, `doOp`, `isMatrixMul1` and `isPos`.
- Handshakes the operand stream and the result streams, and publishes the beat index so the upstream buffer can address sMat/accMat.

Parameters:
- LEN_MAX, 336, maximum beats per command (1344/A for Frodo-1344).
- LW, $clog2(LEN_MAX+1), width of the length field and of the beat index.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_isMul1  in  1  1 = mul1 (outVec += sMat*a), 0 = mul2 (outMat = accMat + sCol*a)
- cmd_isPos  in  1  1 = add, 0 = subtract
- cmd_len  in  LW  number of `a` beats, 0..LEN_MAX
- a_valid  in  1  operand beat (`a`, plus sMat or accMat) present
- a_ready  out  1  operand beat consumed when a_valid&a_ready
- beat_idx  out  LW  index of the current beat, 0-based
- mat_valid  out  1  mul2: outMat valid this cycle
- mat_ready  in  1  mul2 consumer accepts outMat
- mat_last  out  1  mul2: current beat is the last one
- vec_valid  out  1  mul1: outVec (accumulated state) valid
- vec_ready  in  1  mul1 consumer accepts outVec
- done  out  1  one-cycle pulse at the end of a command
- mul_setStorage  out  1  to datapath
- mul_doOp  out  1  to datapath
- mul_isMatrixMul1  out  1  to datapath
- mul_isPos  out  1  to datapath

Behaviour:
- States: IDLE, LOAD, RUN, RESULT, DONE. All are registered; the transition conditions are the only inputs that act combinationally.
- Reset (asynchronous, any state):
  - state=IDLE, beat_idx=0, cfg_isMul1=0, cfg_isPos=1.
  - done, vec_valid, mat_valid, a_ready and mul_setStorage are 0; mul_doOp=0; cmd_ready=1.
  - A command in flight is discarded with no done pulse. Datapath state is undefined afterwards, and the next command reloads it in LOAD.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch isMul1, isPos and len; clear beat_idx; go to LOAD.
  - While no command is accepted, cfg registers hold their last values.
- LOAD (exactly 1 cycle):
  - mul_setStorage=1; the datapath latches accVec (mul1) or sCol (mul2).
  - The requester holds accVec/sCol stable from the command handshake through done.
  - Next state: if len==0, go to RESULT (mul1) or DONE (mul2); otherwise go to RUN.
- RUN:
  - mul1: a_ready=1. mul_doOp = a_valid. On each beat the state accumulates; no result is emitted.
  - mul2: outMat is combinational from the beat. Therefore a_ready=mat_ready, mat_valid=a_valid, and mul_doOp=a_valid&mat_ready. The datapath state (sCol) is unaffected.
  - A beat fires on a_valid&a_ready: beat_idx increments. mat_last = (beat_idx==len-1).
  - On the firing of beat len-1, go to RESULT (mul1) or DONE (mul2). beat_idx wraps to 0 on that transition.
  - A stall (a_valid=0 or mat_ready=0) holds every register, and mul_doOp=0 while stalled.
- RESULT (mul1 only):
  - vec_valid=1 until vec_ready; then go to DONE.
  - doOp=0, so outVec is stable while waiting.
- DONE (1 cycle): done=1, cmd_ready=0, then go to IDLE.
- Datapath mode and sign: mul_isMatrixMul1=cfg_isMul1 and mul_isPos=cfg_isPos, both driven from registers and constant for the whole command.
- Latency:
  - mul1 with no stalls: cmd handshake → done takes len+3 cycles (LOAD, len RUN cycles, RESULT with vec_ready=1, DONE).
  - mul2 with no stalls: len+2 cycles.
  - Back-to-back: a new cmd_ready comes 1 cycle after done.
- Illegal stimulus (assertion): cmd_len>LEN_MAX; mul_setStorage and mul_doOp high together; more than one of vec_valid/mat_valid/mul_setStorage high.
- Arithmetic: beat_idx is an LW-bit unsigned counter, never exceeds len-1 in RUN, and uses no modular wrap beyond the reset to 0.

Decomposition:
- Shared package frodo_mul_pkg holds:
  - the state enum (IDLE/LOAD/RUN/RESULT/DONE);
  - the constants FRODO_A=4, FRODO_S=8, LEN_MAX_640=160, LEN_MAX_976=244, LEN_MAX_1344=336.
- One sub-module: frodo_mul_beat_cnt, a loadable LW-bit counter with clear, enable, and last = (cnt==len-1).

Test Plan:
- mul1, isPos=1, len=4, a_valid always 1, vec_ready=1 → setStorage in cycle 1; doOp in cycles 2-5 with beat_idx 0..3; vec_valid in cycle 6; done in cycle 7; outVec matches accVec + Σ sMat*a mod 2^16.
- mul2, isPos=0, len=3, mat_ready low during beat 1 for 2 cycles → a_ready and doOp low while stalled; beat_idx holds at 1; mat_last only on beat 2; outMat = accMat − sCol*a; done 7 cycles after cmd.
- len=0 in both modes → mul1: LOAD→RESULT, vec_valid shows accVec unchanged, then done; mul2: LOAD→DONE with no mat_valid.
- mul1 len=160, vec_ready held low 5 cycles → vec_valid stays high and outVec stable; done follows the vec_ready cycle; cmd_ready returns the cycle after done.
- Async rst asserted mid-RUN (beat 2 of 4) → outputs immediately at reset values with no done pulse; a new mul2 command with len=2 then completes correctly.
- Back-to-back mul1 len=2 then mul2 len=2 with cmd_valid held → second command accepted 1 cycle after the first done; cfg registers switch exactly at LOAD.

Source files
------------

// File: rtl/frodo_mul_pkg.sv
// Shared definitions for the FrodoKEM multiply-accumulate control path:
// sequencer states and the parameter-set constants.
package frodo_mul_pkg;

  localparam int FRODO_A      = 4;
  localparam int FRODO_S      = 8;
  localparam int LEN_MAX_640  = 160;
  localparam int LEN_MAX_976  = 244;
  localparam int LEN_MAX_1344 = 336;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    RESULT,
    DONE
  } seqState_t;

  // Width needed to hold a beat count of 0..lenMax inclusive.
  function automatic int lenWidth(input int lenMax);
    return $clog2(lenMax + 1);
  endfunction

endpackage

// File: rtl/frodo_mul_seq_if.sv
// Handshake bundle between the sequencer and the upstream operand buffer /
// downstream result consumers.
interface frodo_mul_seq_if #(
  parameter int LEN_MAX = 336,
  parameter int LW      = $clog2(LEN_MAX + 1)
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_isMul1;
  logic          cmd_isPos;
  logic [LW-1:0] cmd_len;

  logic          a_valid;
  logic          a_ready;
  logic [LW-1:0] beat_idx;

  logic          mat_valid;
  logic          mat_ready;
  logic          mat_last;

  logic          vec_valid;
  logic          vec_ready;

  // The master is the requester side (command source, operand buffer, consumers).
  modport master (
    output cmd_valid, cmd_isMul1, cmd_isPos, cmd_len,
    output a_valid, mat_ready, vec_ready,
    input  cmd_ready, a_ready, beat_idx, mat_valid, mat_last, vec_valid
  );

  modport slave (
    input  cmd_valid, cmd_isMul1, cmd_isPos, cmd_len,
    input  a_valid, mat_ready, vec_ready,
    output cmd_ready, a_ready, beat_idx, mat_valid, mat_last, vec_valid
  );

endinterface

// File: rtl/frodo_mul_beat_cnt.sv
// Beat counter: holds the command length, counts fired beats and flags the
// final one so the sequencer can leave RUN and wrap the index to zero.
module frodo_mul_beat_cnt #(
  parameter int LW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          ldLen,
  input  logic [LW-1:0] lenIn,
  output logic [LW-1:0] cnt,
  output logic          last,
  output logic          lenZero
);

  logic [LW-1:0] lenReg;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      lenReg <= '0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (en)
        cnt <= last ? '0 : cnt + 1'b1;
      if (ldLen)
        lenReg <= lenIn;
    end
  end

  assign lenZero = (lenReg == '0);
  // Guarded by lenZero so a zero length never matches the all-ones index.
  assign last    = !lenZero && (cnt == lenReg - 1'b1);

endmodule

// File: rtl/frodo_mul_seq.sv
// Control sequencer for the shared FrodoKEM multiply-accumulate datapath:
// command intake, storage load, operand beats and result handoff.
module frodo_mul_seq
  import frodo_mul_pkg::*;
#(
  parameter int LEN_MAX = LEN_MAX_1344,
  parameter int LW      = $clog2(LEN_MAX + 1)
) (
  input  logic            clk,
  input  logic            rst,
  frodo_mul_seq_if.slave  bus,
  output logic            done,
  output logic            mul_setStorage,
  output logic            mul_doOp,
  output logic            mul_isMatrixMul1,
  output logic            mul_isPos
);

  seqState_t     state;
  seqState_t     stateNext;
  logic          cfgIsMul1;
  logic          cfgIsPos;
  logic          cmdFire;
  logic          beatFire;
  logic          beatLast;
  logic          lenZero;
  logic [LW-1:0] beatIdx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // Mode and sign are captured at the handshake and stay put until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfgIsMul1 <= 1'b0;
      cfgIsPos  <= 1'b1;
    end else if (cmdFire) begin
      cfgIsMul1 <= bus.cmd_isMul1;
      cfgIsPos  <= bus.cmd_isPos;
    end
  end

  frodo_mul_beat_cnt #(.LW(LW)) u_beatCnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cmdFire),
    .en      (beatFire),
    .ldLen   (cmdFire),
    .lenIn   (bus.cmd_len),
    .cnt     (beatIdx),
    .last    (beatLast),
    .lenZero (lenZero)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path through it can leave a signal unassigned and infer a latch.
  always_comb begin
    stateNext      = state;
    cmdFire        = 1'b0;
    beatFire       = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.a_ready    = 1'b0;
    bus.mat_valid  = 1'b0;
    bus.mat_last   = 1'b0;
    bus.vec_valid  = 1'b0;
    done           = 1'b0;
    mul_setStorage = 1'b0;
    mul_doOp       = 1'b0;

    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        cmdFire       = bus.cmd_valid;
        if (bus.cmd_valid)
          stateNext = LOAD;
      end

      LOAD: begin
        mul_setStorage = 1'b1;
        if (!lenZero)
          stateNext = RUN;
        else
          stateNext = cfgIsMul1 ? RESULT : DONE;
      end

      RUN: begin
        if (cfgIsMul1) begin
          bus.a_ready = 1'b1;
          mul_doOp    = bus.a_valid;
        end else begin
          // outMat is combinational from the beat, so the consumer gates the operand.
          bus.a_ready   = bus.mat_ready;
          bus.mat_valid = bus.a_valid;
          bus.mat_last  = beatLast;
          mul_doOp      = bus.a_valid & bus.mat_ready;
        end
        beatFire = bus.a_valid & bus.a_ready;
        if (beatFire && beatLast)
          stateNext = cfgIsMul1 ? RESULT : DONE;
      end

      RESULT: begin
        bus.vec_valid = 1'b1;
        if (bus.vec_ready)
          stateNext = DONE;
      end

      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

  assign bus.beat_idx     = beatIdx;
  assign mul_isMatrixMul1 = cfgIsMul1;
  assign mul_isPos        = cfgIsPos;

  property pLegalLen;
    @(posedge clk) disable iff (rst)
      (state == IDLE && bus.cmd_valid) |-> (bus.cmd_len <= LW'(LEN_MAX));
  endproperty
  aLegalLen: assert property (pLegalLen);

  property pNoLoadDuringOp;
    @(posedge clk) disable iff (rst) !(mul_setStorage && mul_doOp);
  endproperty
  aNoLoadDuringOp: assert property (pNoLoadDuringOp);

  property pExclusivePhase;
    @(posedge clk) disable iff (rst)
      $onehot0({bus.vec_valid, bus.mat_valid, mul_setStorage});
  endproperty
  aExclusivePhase: assert property (pExclusivePhase);

endmodule

// File: tb/tb_frodo_mul_seq.sv
// Directed bench for frodo_mul_seq: cycle-by-cycle strobe, beat index and
// configuration checks against hand-derived sequences.
module tb_frodo_mul_seq;
  import frodo_mul_pkg::*;

  localparam int LEN_MAX = LEN_MAX_1344;
  localparam int LW      = $clog2(LEN_MAX + 1);

  // Strobe vector bit order: {cmd_ready, a_ready, mat_valid, mat_last,
  //                           vec_valid, done, setStorage, doOp}
  localparam logic [7:0] S_IDLE   = 8'b1000_0000;
  localparam logic [7:0] S_LOAD   = 8'b0000_0010;
  localparam logic [7:0] S_RUN1   = 8'b0100_0001;
  localparam logic [7:0] S_RUN2   = 8'b0110_0001;
  localparam logic [7:0] S_LAST2  = 8'b0111_0001;
  localparam logic [7:0] S_STALL2 = 8'b0010_0000;
  localparam logic [7:0] S_RESULT = 8'b0000_1000;
  localparam logic [7:0] S_DONE   = 8'b0000_0100;

  logic clk;
  logic rst;
  logic done;
  logic mul_setStorage;
  logic mul_doOp;
  logic mul_isMatrixMul1;
  logic mul_isPos;

  int vectors;
  int miscompares;

  frodo_mul_seq_if #(.LEN_MAX(LEN_MAX)) bus ();

  frodo_mul_seq #(.LEN_MAX(LEN_MAX)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.slave),
    .done             (done),
    .mul_setStorage   (mul_setStorage),
    .mul_doOp         (mul_doOp),
    .mul_isMatrixMul1 (mul_isMatrixMul1),
    .mul_isPos        (mul_isPos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] strobes();
    return {bus.cmd_ready, bus.a_ready, bus.mat_valid, bus.mat_last,
            bus.vec_valid, done, mul_setStorage, mul_doOp};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle on the current inputs, then compare.
  task automatic expectCycle(input string tag, input logic [7:0] s, input int beat);
    #1;
    check({tag, " strobes"}, {8'h00, strobes()}, {8'h00, s});
    check({tag, " beat"}, 16'(bus.beat_idx), 16'(beat));
  endtask

  task automatic expectCfg(input string tag, input logic isMul1, input logic isPos);
    check({tag, " cfg"}, {14'd0, mul_isMatrixMul1, mul_isPos}, {14'd0, isMul1, isPos});
  endtask

  task automatic offerCmd(input logic isMul1, input logic isPos, input int len);
    bus.cmd_valid  = 1'b1;
    bus.cmd_isMul1 = isMul1;
    bus.cmd_isPos  = isPos;
    bus.cmd_len    = LW'(len);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_isMul1 = 1'b0;
    bus.cmd_isPos  = 1'b0;
    bus.cmd_len    = '0;
    bus.a_valid    = 1'b0;
    bus.mat_ready  = 1'b0;
    bus.vec_ready  = 1'b0;

    // Reset state
    #11;
    expectCycle("reset", S_IDLE, 0);
    expectCfg("reset", 1'b0, 1'b1);
    rst = 1'b0;
    tick();

    // mul1, add, len=4, no stalls: done 7 cycles after the handshake
    bus.a_valid   = 1'b1;
    bus.mat_ready = 1'b1;
    bus.vec_ready = 1'b1;
    offerCmd(1'b1, 1'b1, 4);
    expectCycle("m1 idle", S_IDLE, 0);
    tick(); bus.cmd_valid = 1'b0;
    expectCycle("m1 load", S_LOAD, 0);
    expectCfg("m1 load", 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      expectCycle($sformatf("m1 run%0d", i), S_RUN1, i);
    end
    tick(); expectCycle("m1 result", S_RESULT, 0);
    tick(); expectCycle("m1 done", S_DONE, 0);
    tick(); expectCycle("m1 idle2", S_IDLE, 0);

    // mul2, subtract, len=3, consumer stalls beat 1 for two cycles
    offerCmd(1'b0, 1'b0, 3);
    expectCycle("m2 idle", S_IDLE, 0);
    tick(); bus.cmd_valid = 1'b0;
    expectCycle("m2 load", S_LOAD, 0);
    expectCfg("m2 load", 1'b0, 1'b0);
    tick(); expectCycle("m2 beat0", S_RUN2, 0);
    tick(); bus.mat_ready = 1'b0;
    expectCycle("m2 stall a", S_STALL2, 1);
    tick(); expectCycle("m2 stall b", S_STALL2, 1);
    tick(); bus.mat_ready = 1'b1;
    expectCycle("m2 beat1", S_RUN2, 1);
    tick(); expectCycle("m2 beat2", S_LAST2, 2);
    tick(); expectCycle("m2 done", S_DONE, 0);
    tick(); expectCycle("m2 idle2", S_IDLE, 0);

    // len=0, mul1: LOAD straight to RESULT
    offerCmd(1'b1, 1'b1, 0);
    expectCycle("z1 idle", S_IDLE, 0);
    tick(); bus.cmd_valid = 1'b0;
    expectCycle("z1 load", S_LOAD, 0);
    tick(); expectCycle("z1 result", S_RESULT, 0);
    tick(); expectCycle("z1 done", S_DONE, 0);
    tick(); expectCycle("z1 idle2", S_IDLE, 0);

    // len=0, mul2: LOAD straight to DONE, no mat_valid
    offerCmd(1'b0, 1'b1, 0);
    expectCycle("z2 idle", S_IDLE, 0);
    tick(); bus.cmd_valid = 1'b0;
    expectCycle("z2 load", S_LOAD, 0);
    tick(); expectCycle("z2 done", S_DONE, 0);
    tick(); expectCycle("z2 idle2", S_IDLE, 0);

    // mul1 len=160 (Frodo-640 length), result consumer stalls 5 cycles
    bus.vec_ready = 1'b0;
    offerCmd(1'b1, 1'b1, LEN_MAX_640);
    expectCycle("l1 idle", S_IDLE, 0);
    tick(); bus.cmd_valid = 1'b0;
    expectCycle("l1 load", S_LOAD, 0);
    for (int i = 0; i < LEN_MAX_640; i++) begin
      tick();
      expectCycle($sformatf("l1 run%0d", i), S_RUN1, i);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      expectCycle($sformatf("l1 wait%0d", i), S_RESULT, 0);
    end
    tick(); bus.vec_ready = 1'b1;
    expectCycle("l1 accept", S_RESULT, 0);
    tick(); expectCycle("l1 done", S_DONE, 0);
    tick(); expectCycle("l1 idle2", S_IDLE, 0);

    // Async reset at beat 2 of a 4-beat mul1: no done pulse, cfg back to reset
    offerCmd(1'b1, 1'b0, 4);
    expectCycle("r idle", S_IDLE, 0);
    tick(); bus.cmd_valid = 1'b0;
    expectCycle("r load", S_LOAD, 0);
    tick(); expectCycle("r beat0", S_RUN1, 0);
    tick(); expectCycle("r beat1", S_RUN1, 1);
    tick(); expectCycle("r beat2", S_RUN1, 2);
    expectCfg("r before", 1'b1, 1'b0);
    rst = 1'b1;
    expectCycle("r asserted", S_IDLE, 0);
    expectCfg("r asserted", 1'b0, 1'b1);
    tick(); expectCycle("r held", S_IDLE, 0);
    rst = 1'b0;
    tick(); expectCycle("r after a", S_IDLE, 0);
    tick(); expectCycle("r after b", S_IDLE, 0);

    // Recovery: mul2 len=2 completes normally
    offerCmd(1'b0, 1'b1, 2);
    expectCycle("rc idle", S_IDLE, 0);
    tick(); bus.cmd_valid = 1'b0;
    expectCycle("rc load", S_LOAD, 0);
    expectCfg("rc load", 1'b0, 1'b1);
    tick(); expectCycle("rc beat0", S_RUN2, 0);
    tick(); expectCycle("rc beat1", S_LAST2, 1);
    tick(); expectCycle("rc done", S_DONE, 0);
    tick(); expectCycle("rc idle2", S_IDLE, 0);

    // Back-to-back: mul1 len=2 then mul2 len=2 with cmd_valid held
    offerCmd(1'b1, 1'b1, 2);
    expectCycle("bb idle", S_IDLE, 0);
    tick(); offerCmd(1'b0, 1'b0, 2);
    expectCycle("bb load1", S_LOAD, 0);
    expectCfg("bb load1", 1'b1, 1'b1);
    tick(); expectCycle("bb1 beat0", S_RUN1, 0);
    tick(); expectCycle("bb1 beat1", S_RUN1, 1);
    tick(); expectCycle("bb1 result", S_RESULT, 0);
    tick(); expectCycle("bb1 done", S_DONE, 0);
    tick(); expectCycle("bb accept2", S_IDLE, 0);
    expectCfg("bb accept2", 1'b1, 1'b1);
    tick(); bus.cmd_valid = 1'b0;
    expectCycle("bb load2", S_LOAD, 0);
    expectCfg("bb load2", 1'b0, 1'b0);
    tick(); expectCycle("bb2 beat0", S_RUN2, 0);
    tick(); expectCycle("bb2 beat1", S_LAST2, 1);
    tick(); expectCycle("bb2 done", S_DONE, 0);
    tick(); expectCycle("bb idle2", S_IDLE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
